// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_t;

   // RV32I load/store width and sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // fault_cause encodings
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // lane select followed by extension according to the load flavour
   always_comb begin
      case (offset)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_BU:   result = {24'h000000, byte_sel};
         F3_HU:   result = {16'h0000, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access engine: req/gnt + rvalid handshake, store lane
// steering, load alignment/extension, pipeline stall and fault reporting.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_load,
   input  logic        op_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             is_load_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;

   logic             op_one;
   logic             f3_ok;
   logic             acc_illegal;
   logic             acc_misalign;
   logic             acc_legal;
   logic [3:0]       be_next;
   logic [31:0]      wdata_next;
   logic [31:0]      ext_data;

   load_extend u_load_extend (
      .rdata  (mem_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .result (ext_data)
   );

   // classify the execute-stage op and build store lanes
   always_comb begin
      op_one = op_load ^ op_store;
      if (op_store)
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      acc_illegal  = op_valid && !(op_one && f3_ok);
      acc_misalign = op_valid && op_one && f3_ok &&
                     (((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
      acc_legal    = op_valid && op_one && f3_ok && !acc_misalign;

      be_next    = 4'b1111;
      wdata_next = 32'h0;
      if (op_store) begin
         case (funct3)
            F3_B: begin
               be_next    = 4'b0001 << addr[1:0];
               wdata_next = {4{store_data[7:0]}};
            end
            F3_H: begin
               be_next    = 4'b0011 << {addr[1], 1'b0};
               wdata_next = {2{store_data[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = store_data;
            end
         endcase
      end

      stall = ((state == ST_IDLE) && acc_legal) ||
              (state == ST_REQ) || (state == ST_WAIT);
   end

   // capture the accepted op's attributes for the rest of the access
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && acc_legal) begin
         is_load_q <= op_load;
         f3_q      <= funct3;
         off_q     <= addr[1:0];
      end
   end

   // access sequencer with registered bus and result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         load_data   <= 32'h0;
         load_valid  <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= CAUSE_NONE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0;
         mem_be      <= 4'b0000;
         mem_wdata   <= 32'h0;
      end else begin
         load_valid  <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= CAUSE_NONE;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (acc_illegal) begin
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_ILLEGAL;
               end else if (acc_misalign) begin
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_MISALIGN;
               end else if (acc_legal) begin
                  state     <= ST_REQ;
                  mem_req   <= 1'b1;
                  mem_we    <= op_store;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= be_next;
                  mem_wdata <= wdata_next;
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  cnt     <= '0;
                  state   <= is_load_q ? ST_WAIT : ST_DONE;
               end else if (cnt == CNT_LAST) begin
                  mem_req     <= 1'b0;
                  load_data   <= 32'h0;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
                  cnt         <= '0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  load_data  <= ext_data;
                  load_valid <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_DONE;
               end else if (cnt == CNT_LAST) begin
                  load_data   <= 32'h0;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
                  cnt         <= '0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, rejects, timeout, reset.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid, op_load, op_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        no_gnt;

   logic        stall, load_valid, fault, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [1:0]  fault_cause;
   logic [3:0]  mem_be;

   logic        to_stall, to_load_valid, to_fault, to_mem_req, to_mem_we;
   logic [31:0] to_load_data, to_mem_addr, to_mem_wdata;
   logic [1:0]  to_fault_cause;
   logic [3:0]  to_mem_be;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_load(op_load),
      .op_store(op_store), .funct3(funct3), .addr(addr), .store_data(store_data),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // short-timeout instance whose bus never answers
   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_load(op_load),
      .op_store(op_store), .funct3(funct3), .addr(addr), .store_data(store_data),
      .stall(to_stall), .load_data(to_load_data), .load_valid(to_load_valid),
      .fault(to_fault), .fault_cause(to_fault_cause), .mem_req(to_mem_req),
      .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_be(to_mem_be),
      .mem_wdata(to_mem_wdata), .mem_gnt(no_gnt), .mem_rvalid(no_gnt),
      .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
      op_valid = 1'b1; op_load = ld; op_store = st;
      funct3 = f3; addr = a; store_data = sd;
      #1;
   endtask

   task automatic clr_op();
      op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
   endtask

   task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
      put_op(1'b1, 1'b0, f3, a, 32'h0);
      check({nm, ":stall_accept"}, stall, 1);
      step(); clr_op();
      check({nm, ":req"}, mem_req, 1);
      check({nm, ":addr"}, mem_addr, {a[31:2], 2'b00});
      check({nm, ":be"}, mem_be, 4'b1111);
      check({nm, ":we"}, mem_we, 0);
      check({nm, ":stall_req"}, stall, 1);
      mem_gnt = 1'b1;
      step(); mem_gnt = 1'b0;
      check({nm, ":req_drop"}, mem_req, 0);
      check({nm, ":stall_wait"}, stall, 1);
      mem_rvalid = 1'b1; mem_rdata = rd;
      step(); mem_rvalid = 1'b0;
      check({nm, ":valid"}, load_valid, 1);
      check({nm, ":data"}, load_data, exp);
      check({nm, ":stall_done"}, stall, 0);
      step();
      check({nm, ":valid_pulse"}, load_valid, 0);
      check({nm, ":data_hold"}, load_data, exp);
      check({nm, ":stall_idle"}, stall, 0);
   endtask

   task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [3:0] be,
                           input logic [31:0] wd, input int gdly);
      put_op(1'b0, 1'b1, f3, a, sd);
      check({nm, ":stall_accept"}, stall, 1);
      step(); clr_op();
      for (int i = 0; i <= gdly; i++) begin
         check({nm, ":req"}, mem_req, 1);
         check({nm, ":we"}, mem_we, 1);
         check({nm, ":addr"}, mem_addr, {a[31:2], 2'b00});
         check({nm, ":be"}, mem_be, be);
         check({nm, ":wdata"}, mem_wdata, wd);
         check({nm, ":stall_req"}, stall, 1);
         if (i < gdly) step();
      end
      mem_gnt = 1'b1;
      step(); mem_gnt = 1'b0;
      check({nm, ":req_drop"}, mem_req, 0);
      check({nm, ":stall_done"}, stall, 0);
      check({nm, ":no_fault"}, fault, 0);
      step();
      check({nm, ":stall_idle"}, stall, 0);
   endtask

   task automatic do_reject(input string nm, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] cause);
      put_op(ld, st, f3, a, 32'h0);
      check({nm, ":stall"}, stall, 0);
      step(); clr_op();
      check({nm, ":fault"}, fault, 1);
      check({nm, ":cause"}, fault_cause, cause);
      check({nm, ":no_req"}, mem_req, 0);
      check({nm, ":stall_after"}, stall, 0);
      step();
      check({nm, ":fault_pulse"}, fault, 0);
      check({nm, ":no_req2"}, mem_req, 0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clr_op(); funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; no_gnt = 1'b0;
      step(); step();
      check("rst:req", mem_req, 0);
      check("rst:load_data", load_data, 0);
      check("rst:load_valid", load_valid, 0);
      check("rst:fault", fault, 0);
      check("rst:cause", fault_cause, 0);
      check("rst:addr", mem_addr, 0);
      check("rst:be", mem_be, 0);
      check("rst:stall", stall, 0);
      reset = 1'b0;
      step();

      do_load("lw",  3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'hDEADBEEF);
      do_load("lb",  3'b000, 32'h0000_0103, 32'h80112233, 32'hFFFFFF80);
      do_load("lbu", 3'b100, 32'h0000_0103, 32'h80112233, 32'h00000080);
      do_load("lhu", 3'b101, 32'h0000_0102, 32'h80112233, 32'h00008011);
      do_load("lh",  3'b001, 32'h0000_0102, 32'h80112233, 32'hFFFF8011);
      do_load("lb0", 3'b000, 32'h0000_0100, 32'h80112233, 32'h00000033);

      do_store("sb", 3'b000, 32'h0000_0201, 32'h000000AB, 4'b0010, 32'hABABABAB, 5);
      do_store("sh", 3'b001, 32'h0000_0206, 32'h1234CDEF, 4'b1100, 32'hCDEFCDEF, 0);
      do_store("sw", 3'b010, 32'h0000_0208, 32'h11223344, 4'b1111, 32'h11223344, 1);

      do_reject("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0102, 2'b01);
      do_reject("sh_mis",  1'b0, 1'b1, 3'b001, 32'h0000_0203, 2'b01);
      do_reject("st_f3",   1'b0, 1'b1, 3'b100, 32'h0000_0200, 2'b10);
      do_reject("ld_f3",   1'b1, 1'b0, 3'b011, 32'h0000_0200, 2'b10);
      do_reject("both",    1'b1, 1'b1, 3'b010, 32'h0000_0200, 2'b10);
      do_reject("neither", 1'b0, 1'b0, 3'b010, 32'h0000_0200, 2'b10);

      // timeout on the short-timeout instance, gnt never arrives
      pulse_reset();
      put_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
      step(); clr_op();
      check("to:req1", to_mem_req, 1);
      check("to:addr", to_mem_addr, 32'h0000_0300);
      check("to:be", to_mem_be, 4'b1111);
      check("to:we", to_mem_we, 0);
      check("to:stall1", to_stall, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("to:req_held", to_mem_req, 1);
         check("to:stall_held", to_stall, 1);
         check("to:no_early_fault", to_fault, 0);
      end
      step();
      check("to:req_drop", to_mem_req, 0);
      check("to:fault", to_fault, 1);
      check("to:cause", to_fault_cause, 2'b11);
      check("to:stall_rel", to_stall, 0);
      check("to:no_valid", to_load_valid, 0);
      check("to:data", to_load_data, 0);
      step();
      check("to:fault_pulse", to_fault, 0);

      // reset asserted while a load waits for rvalid
      pulse_reset();
      do_load("pre", 3'b010, 32'h0000_0400, 32'h55AA55AA, 32'h55AA55AA);
      put_op(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0);
      step(); clr_op();
      mem_gnt = 1'b1;
      step(); mem_gnt = 1'b0;
      check("rw:stall_wait", stall, 1);
      reset = 1'b1;
      step(); reset = 1'b0;
      check("rw:req", mem_req, 0);
      check("rw:data", load_data, 0);
      check("rw:valid", load_valid, 0);
      check("rw:stall", stall, 0);
      check("rw:be", mem_be, 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      step(); mem_rvalid = 1'b0;
      check("rw:late_valid", load_valid, 0);
      check("rw:late_data", load_data, 0);
      check("rw:late_stall", stall, 0);
      do_load("post", 3'b010, 32'h0000_0104, 32'hCAFEF00D, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
